// File: rtl/cordiv_pkg.sv
// Shared types and helpers for the multi-lane correlated stochastic divider.
// Contents: run-controller state encoding and the tap-select width helper.
// No ports; imported by cordiv_lane and cordiv_multi.
package cordiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a tap index into a shift register of the given depth; never 0.
    function automatic int tap_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/cordiv_lane.sv
// One correlated-division lane: tap mux, quotient select, shift register, ones counter.
// Latency: quotient_o is combinational from dividend_i/divisor_i; sr/count update at the next edge.
// Backpressure: none, one sample per enabled cycle.
// Ports: clr_i clears sr and count, en_i marks a RUN cycle, tap_i picks the held bit,
//        quotient_o is gated by en_i, count_o is the running ones count.
module cordiv_lane
    import cordiv_pkg::*;
#(
    parameter int SRDEPTH = 4,
    parameter int CNTW    = 8,
    parameter int TW      = tap_w(SRDEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [TW-1:0]   tap_i,
    input  logic            dividend_i,
    input  logic            divisor_i,
    output logic            quotient_o,
    output logic [CNTW-1:0] count_o
);

    logic [SRDEPTH-1:0] sr_q, sr_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               q_raw;

    always_comb begin
        // With divisor low the lane replays a previously emitted quotient bit.
        q_raw = divisor_i ? dividend_i : sr_q[tap_i];
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (en_i) begin
            // Only cycles with a real divisor sample feed the history; sr[0] is newest.
            if (divisor_i) begin
                sr_d = {sr_q[SRDEPTH-2:0], q_raw};
            end
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, q_raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o = en_i & q_raw;
    assign count_o    = cnt_q;

endmodule

// File: rtl/cordiv_multi.sv
// NCH-lane stochastic divider with a start/busy/done bounded-length run controller.
// Latency: quotient combinational during RUN; done pulses len+1 cycles after start is accepted.
// Backpressure: none; start is only honoured in IDLE, ignored while a run is in flight.
// Ports: start/len/srSel request a run; dividend/divisor are per-lane bits; quotient is the
//        per-lane result (0 outside RUN); busy marks RUN; done is a one-cycle end pulse;
//        qcount packs per-lane ones counts, lane i at [i*CNTW +: CNTW].
module cordiv_multi
    import cordiv_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int SRDEPTH = 4,
    parameter  int CNTW    = 8,
    localparam int TW      = tap_w(SRDEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNTW-1:0]     len,
    input  logic [TW-1:0]       srSel,
    input  logic [NCH-1:0]      dividend,
    input  logic [NCH-1:0]      divisor,
    output logic [NCH-1:0]      quotient,
    output logic                busy,
    output logic                done,
    output logic [NCH*CNTW-1:0] qcount
);

    localparam logic [TW-1:0]   TAP_MAX = TW'(SRDEPTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cyc_q, cyc_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [TW-1:0]   tap_q, tap_d;
    logic [TW-1:0]   sel_clamped;
    logic            lane_clr;
    logic            lane_en;

    // A tap beyond the register depth reads the oldest stored bit instead.
    assign sel_clamped = (int'(srSel) >= SRDEPTH) ? TAP_MAX : srSel;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        len_d    = len_q;
        tap_d    = tap_q;
        lane_clr = 1'b0;
        lane_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Counts clear on any accepted start, including a zero-length run.
                    lane_clr = 1'b1;
                    cyc_d    = '0;
                    if (len != '0) begin
                        len_d   = len;
                        tap_d   = sel_clamped;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                lane_en = 1'b1;
                busy    = 1'b1;
                cyc_d   = cyc_q + CNT_ONE;
                // cyc_q counts samples already taken; this cycle takes sample cyc_q+1.
                if (cyc_q + CNT_ONE == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            len_q   <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            len_q   <= len_d;
            tap_q   <= tap_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        cordiv_lane #(
            .SRDEPTH (SRDEPTH),
            .CNTW    (CNTW),
            .TW      (TW)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (lane_clr),
            .en_i       (lane_en),
            .tap_i      (tap_q),
            .dividend_i (dividend[i]),
            .divisor_i  (divisor[i]),
            .quotient_o (quotient[i]),
            .count_o    (qcount[i*CNTW +: CNTW])
        );
    end

endmodule

// File: tb/tb_cordiv_multi.sv
// Directed bench for cordiv_multi: passthrough, hold/tap, zero/clamp, handshake,
// mid-run reset and a deterministic correlated-stream statistical run.
module tb_cordiv_multi;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [1:0]  srSel;
    logic [3:0]  dividend;
    logic [3:0]  divisor;
    logic [3:0]  quotient;
    logic        busy;
    logic        done;
    logic [31:0] qcount;

    // Second instance with a non power-of-two depth so an out-of-range tap is representable.
    logic        c_start;
    logic [7:0]  c_len;
    logic [2:0]  c_sel;
    logic [0:0]  c_dvd;
    logic [0:0]  c_dvs;
    logic [0:0]  c_q;
    logic        c_busy;
    logic        c_done;
    logic [7:0]  c_qcount;

    int n_checks;
    int n_fails;

    logic [3:0] v_dvd [0:255];
    logic [3:0] v_dvs [0:255];
    logic [3:0] v_q   [0:255];

    cordiv_multi #(.NCH(4), .SRDEPTH(4), .CNTW(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .srSel    (srSel),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .busy     (busy),
        .done     (done),
        .qcount   (qcount)
    );

    cordiv_multi #(.NCH(1), .SRDEPTH(5), .CNTW(8)) u_clamp (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (c_start),
        .len      (c_len),
        .srSel    (c_sel),
        .dividend (c_dvd),
        .divisor  (c_dvs),
        .quotient (c_q),
        .busy     (c_busy),
        .done     (c_done),
        .qcount   (c_qcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] brev(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[7-b];
        return r;
    endfunction

    // Runs n cycles from the vector tables; hammer keeps start high through RUN and DONE.
    task automatic run(input int n, input logic [1:0] sel, input bit chk_q, input bit hammer);
        @(negedge clk);
        start = 1'b1;
        len   = n[7:0];
        srSel = sel;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start = hammer;
            if (hammer) begin
                len   = 8'd200;
                srSel = ~sel;
            end
            dividend = v_dvd[c];
            divisor  = v_dvs[c];
            #1;
            check($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("no_done_c%0d", c), 32'(done), 32'd0);
            if (chk_q) check($sformatf("quotient_c%0d", c), 32'(quotient), 32'(v_q[c]));
        end
        @(negedge clk);
        start = hammer;
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("quotient_at_done", 32'(quotient), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_cleared", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [6:0] cdvs;
        logic [6:0] cdvd;
        logic [6:0] cexp;
        logic [7:0] r;
        logic [7:0] cnt;
        int         idx;

        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 8'd0;
        srSel    = 2'd0;
        dividend = 4'h0;
        divisor  = 4'h0;
        c_start  = 1'b0;
        c_len    = 8'd0;
        c_sel    = 3'd0;
        c_dvd    = 1'b0;
        c_dvs    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        dividend = 4'hF;
        divisor  = 4'hF;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_qcount", qcount, 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Passthrough: lane0 10110010, lane1 its complement, lane2 ones, lane3 zeros
        pat = 8'b10110010;
        for (int c = 0; c < 8; c++) begin
            v_dvd[c] = {1'b0, 1'b1, ~pat[7-c], pat[7-c]};
            v_dvs[c] = 4'hF;
            v_q[c]   = v_dvd[c];
        end
        run(8, 2'd0, 1'b1, 1'b0);
        check("pass_qcount", qcount, 32'h0008_0404);

        // Zero with tap 3: lane2 history is all ones from the previous run and must clear
        for (int c = 0; c < 5; c++) begin
            v_dvd[c] = 4'hF;
            v_dvs[c] = 4'h0;
            v_q[c]   = 4'h0;
        end
        run(5, 2'd3, 1'b1, 1'b0);
        check("zero_qcount", qcount, 32'd0);

        // Hold/tap: lane0 (1,1),(1,0),(0,x),(0,x) with tap 1 -> 1,0,1,1
        v_dvs[0] = 4'b0001; v_dvd[0] = 4'b1111; v_q[0] = 4'b0001;
        v_dvs[1] = 4'b0001; v_dvd[1] = 4'b1110; v_q[1] = 4'b0000;
        v_dvs[2] = 4'b0000; v_dvd[2] = 4'b1111; v_q[2] = 4'b0001;
        v_dvs[3] = 4'b0000; v_dvd[3] = 4'b1110; v_q[3] = 4'b0001;
        run(4, 2'd1, 1'b1, 1'b0);
        check("hold_qcount", qcount, 32'h0000_0003);

        // Clamp on depth 5: srSel 7 must read tap 4, the bit shifted in five samples ago
        cdvs = 7'b1111100;
        cdvd = 7'b1000010;
        cexp = 7'b1000011;
        @(negedge clk);
        c_start = 1'b1;
        c_len   = 8'd7;
        c_sel   = 3'd7;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            c_start = 1'b0;
            c_sel   = 3'd0;
            c_dvs   = cdvs[6-c];
            c_dvd   = cdvd[6-c];
            #1;
            check($sformatf("clamp_q_c%0d", c), 32'(c_q), 32'(cexp[6-c]));
        end
        @(negedge clk);
        #1;
        check("clamp_done", 32'(c_done), 32'd1);
        check("clamp_qcount", 32'(c_qcount), 32'd3);

        // len=0: done at k+1, busy never high, counts cleared
        @(negedge clk);
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_qcount", qcount, 32'd0);
        @(negedge clk);
        #1;
        check("len0_done_clear", 32'(done), 32'd0);
        check("len0_busy_after", 32'(busy), 32'd0);

        // Handshake: start held high through RUN and DONE must not restart or stretch
        v_dvd[0] = 4'b0101; v_dvd[1] = 4'b1010; v_dvd[2] = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            v_dvs[c] = 4'hF;
            v_q[c]   = v_dvd[c];
        end
        run(3, 2'd0, 1'b1, 1'b1);
        check("hammer_qcount", qcount, 32'h0202_0202);
        @(negedge clk);
        #1;
        check("hammer_idle_busy", 32'(busy), 32'd0);
        check("hammer_idle_done", 32'(done), 32'd0);

        // Reset mid-run of a len=10 run at cycle k+3
        @(negedge clk);
        start = 1'b1;
        len   = 8'd10;
        srSel = 2'd0;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'hF;
        divisor  = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("prerst_qcount", qcount, 32'h0202_0202);
        check("prerst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_qcount", qcount, 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("midrst_no_done_c%0d", c), 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v_dvd[0] = 4'b0011; v_dvs[0] = 4'hF; v_q[0] = 4'b0011;
        v_dvd[1] = 4'b0001; v_dvs[1] = 4'hF; v_q[1] = 4'b0001;
        run(2, 2'd0, 1'b1, 1'b0);
        check("postrst_qcount", qcount, 32'h0000_0102);

        // Statistical: correlated streams from a bit-reversed counter, P(dividend)=0.25,
        // P(divisor)=0.5, so every lane should count close to 128 of 255.
        for (int c = 0; c < 255; c++) begin
            for (int j = 0; j < 4; j++) begin
                idx = c + j;
                r   = brev(idx[7:0]);
                v_dvd[c][j] = (r < 8'd64);
                v_dvs[c][j] = (r < 8'd128);
            end
        end
        run(255, 2'd0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cnt = qcount[j*8 +: 8];
            check($sformatf("stat_lane%0d_count%0d_in_115_141", j, cnt),
                  32'((cnt >= 8'd115) && (cnt <= 8'd141)), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
